// File: rtl/mem_cache.sv
// Direct-mapped word cache in front of a single-request backing memory:
// write-through/no-allocate, read fill on miss, one-cycle flush, saturating hit/miss counters.
module mem_cache #(
    parameter int ADDR_W = 22,
    parameter int DATA_W = 32,
    parameter int LINES  = 64,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              cmd,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              flush,
    output logic              stall,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              cache_hit,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - IDX_W;

    typedef enum logic [1:0] {IDLE, FILL, WRITE, FLUSH} state_t;
    state_t state;

    logic [LINES-1:0]  valid;
    logic [TAG_W-1:0]  tags  [LINES];
    logic [DATA_W-1:0] words [LINES];

    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] ack_idx;
    logic [TAG_W-1:0] tag;
    logic [TAG_W-1:0] ack_tag;
    logic             lookup_hit;
    logic             ack_hit;

    assign idx        = addr[IDX_W-1:0];
    assign tag        = addr[ADDR_W-1:IDX_W];
    assign ack_idx    = mem_addr[IDX_W-1:0];
    assign ack_tag    = mem_addr[ADDR_W-1:IDX_W];
    assign lookup_hit = valid[idx] && (tags[idx] == tag);
    assign ack_hit    = valid[ack_idx] && (tags[ack_idx] == ack_tag);

    // Stall is combinational so a miss/write holds the pipeline in the very cycle it is seen.
    always_comb begin
        stall = 1'b0;
        if (rst_n) begin
            case (state)
                IDLE:        stall = flush || (req_valid && (cmd || !lookup_hit));
                FILL, WRITE: stall = !mem_ack;
                FLUSH:       stall = 1'b1;
                default:     stall = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            valid     <= '0;
            rd_valid  <= 1'b0;
            cache_hit <= 1'b0;
            rd_data   <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            hit_cnt   <= '0;
            miss_cnt  <= '0;
        end else begin
            rd_valid  <= 1'b0;
            cache_hit <= 1'b0;
            case (state)
                IDLE: begin
                    if (flush) begin
                        state <= FLUSH;
                    end else if (req_valid) begin
                        if (cmd) begin
                            state     <= WRITE;
                            mem_req   <= 1'b1;
                            mem_we    <= 1'b1;
                            mem_addr  <= addr;
                            mem_wdata <= wr_data;
                        end else if (lookup_hit) begin
                            rd_valid  <= 1'b1;
                            cache_hit <= 1'b1;
                            rd_data   <= words[idx];
                            if (hit_cnt != '1) hit_cnt <= hit_cnt + CNT_W'(1);
                        end else begin
                            state    <= FILL;
                            mem_req  <= 1'b1;
                            mem_we   <= 1'b0;
                            mem_addr <= addr;
                            if (miss_cnt != '1) miss_cnt <= miss_cnt + CNT_W'(1);
                        end
                    end
                end
                FILL: begin
                    if (mem_ack) begin
                        state          <= IDLE;
                        mem_req        <= 1'b0;
                        valid[ack_idx] <= 1'b1;
                        rd_valid       <= 1'b1;
                        rd_data        <= mem_rdata;
                    end
                end
                WRITE: begin
                    if (mem_ack) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                    end
                end
                FLUSH: begin
                    state <= IDLE;
                    valid <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tag/data arrays carry no reset; an aborted access cannot write because reset forces IDLE.
    always_ff @(posedge clk) begin
        if (mem_ack && state == FILL) begin
            tags[ack_idx]  <= ack_tag;
            words[ack_idx] <= mem_rdata;
        end else if (mem_ack && state == WRITE && ack_hit) begin
            words[ack_idx] <= mem_wdata;
        end
    end

endmodule

// File: doc/mem_cache.md
MEM_CACHE -- requirements
Module: mem_cache

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- ADDR_W, 22, word-address width.
- DATA_W, 32, data width.
- LINES, 64, number of direct-mapped lines; power of 2, >=2.
- CNT_W, 16, width of the hit and miss counters.
REQ-002 Derived widths SHALL be:
- IDX_W = log2(LINES).
- TAG_W = ADDR_W - IDX_W.
REQ-003 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, single clock; all logic on the rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- req_valid, in, 1, pipeline access request.
- cmd, in, 1, 1=write, 0=read.
- addr, in, ADDR_W, word address.
- wr_data, in, DATA_W, write data.
- flush, in, 1, invalidate all lines.
- stall, out, 1, pipeline must hold its request stable.
- rd_valid, out, 1, rd_data valid this cycle.
- rd_data, out, DATA_W, read result.
- cache_hit, out, 1, pulses with rd_valid when the read hit.
- mem_req, out, 1, backing-memory request, held until ack.
- mem_we, out, 1, backing write.
- mem_addr, out, ADDR_W, backing address.
- mem_wdata, out, DATA_W, backing write data.
- mem_ack, in, 1, one-cycle backing completion.
- mem_rdata, in, DATA_W, valid with mem_ack on reads.
- hit_cnt, out, CNT_W, saturating read-hit count.
- miss_cnt, out, CNT_W, saturating read-miss count.

Function
REQ-004 Address split SHALL be: index = addr[IDX_W-1:0], tag = addr[ADDR_W-1:IDX_W]; each line SHALL hold a valid bit, a TAG_W tag and a DATA_W word.
REQ-005 The FSM SHALL have four states with these transitions:
- IDLE to FILL on a read miss.
- IDLE to WRITE on a write.
- FILL to IDLE on mem_ack.
- WRITE to IDLE on mem_ack.
- IDLE to FLUSH on flush; FLUSH to IDLE unconditionally after one cycle.
REQ-006 In IDLE, flush SHALL have priority over req_valid; the request that cycle is stalled, not lost.
REQ-007 Read hit in IDLE: stall=0; rd_valid=1, cache_hit=1 and rd_data=line word on the next cycle; hit_cnt+1.
REQ-008 Read miss in IDLE:
- stall=1 combinationally that cycle and throughout FILL.
- mem_req=1, mem_we=0 and mem_addr=addr from the first FILL cycle until mem_ack.
- miss_cnt+1, counted once per miss.
REQ-009 On mem_ack in FILL:
- The line SHALL be written with valid=1, tag and mem_rdata.
- stall SHALL deassert in that cycle.
- rd_valid=1, cache_hit=0 and rd_data=mem_rdata on the next cycle.
REQ-010 Write in IDLE (write-through, no-allocate):
- stall=1 until mem_ack.
- mem_req=1, mem_we=1, mem_addr=addr, mem_wdata=wr_data.
- On a tag hit the line word SHALL be updated at mem_ack.
- A write miss SHALL NOT allocate.
- Writes SHALL NOT change the counters.
- rd_valid SHALL stay 0.
REQ-011 FLUSH SHALL clear all valid bits in one cycle; tags, data and counters are unchanged; stall=1 during FLUSH.
REQ-012 mem_ack outside FILL/WRITE SHALL be ignored.
REQ-013 flush and req_valid arriving during FILL/WRITE SHALL NOT be registered; the pipeline keeps them asserted under stall.
REQ-014 hit_cnt and miss_cnt SHALL saturate at all-ones.
REQ-015 rd_valid and cache_hit SHALL be single-cycle pulses; rd_data SHALL hold its last value otherwise.
REQ-016 A read to the address just filled SHALL hit on the next IDLE access.

Reset
REQ-017 rst_n low SHALL asynchronously force:
- state = IDLE.
- All valid bits = 0.
- stall, rd_valid, cache_hit, mem_req, mem_we = 0.
- mem_addr, mem_wdata, rd_data = 0.
- hit_cnt, miss_cnt = 0.
REQ-018 Reset during FILL/WRITE SHALL abort the access with no line update; a mem_ack arriving after reset release SHALL be ignored.

Verification
REQ-019 Cold read addr=0x000005, mem_rdata=0xDEADBEEF, ack after 3 cycles -> stall high 4 cycles, mem_req/mem_addr=0x000005 held, rd_valid with rd_data=0xDEADBEEF and cache_hit=0, miss_cnt=1.
REQ-020 Repeat read of 0x000005 -> stall=0, next-cycle rd_valid=1, cache_hit=1, rd_data=0xDEADBEEF, hit_cnt=1, no mem_req.
REQ-021 Conflict test (LINES=64):
- Read 0x000045 (same index 5, new tag) -> miss and refill.
- Then read 0x000005 -> miss again; miss_cnt=3.
REQ-022 Write-through:
- Write 0x12345678 to resident 0x000045 -> mem_we=1 until ack, and the following read hits with 0x12345678.
- Write to non-resident 0x000100 -> no allocate; the next read of 0x000100 misses.
REQ-023 Flush asserted together with req_valid read of a resident address -> FLUSH cycle with stall=1, then the read misses; counters otherwise unchanged.
REQ-024 Reset/saturation:
- rst_n pulsed low mid-FILL -> all outputs 0, a late mem_ack is ignored, the previously resident line misses.
- With CNT_W=2, four hits -> hit_cnt holds at 3.
